// File: rtl/dispatch_ctrl.sv
// Single-entry issue stage: holds one decoded instruction, checks a register scoreboard
// and strobes it to the ALU/DIV/MEM/CSR unit, raising an exception pulse for illegal entries.
module dispatch_ctrl #(
    parameter int ADDR = 32,
    parameter int CMD  = 8,
    parameter int IMM  = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dec_e_,
    input  logic [ADDR-1:0] dec_pc,
    input  logic [1:0]      dec_rs1_type,
    input  logic [1:0]      dec_rs2_type,
    input  logic [1:0]      dec_rd_type,
    input  logic [4:0]      dec_rs1_addr,
    input  logic [4:0]      dec_rs2_addr,
    input  logic [4:0]      dec_rd_addr,
    input  logic            dec_invalid,
    input  logic [IMM-1:0]  dec_imm,
    input  logic [2:0]      dec_unit,
    input  logic [CMD-1:0]  dec_cmd,
    output logic            is_full,
    input  logic            alu_ready,
    input  logic            div_ready,
    input  logic            mem_ready,
    input  logic            csr_ready,
    output logic            alu_issue,
    output logic            div_issue,
    output logic            mem_issue,
    output logic            csr_issue,
    output logic [ADDR-1:0] iss_pc,
    output logic [6:0]      iss_rs1,
    output logic [6:0]      iss_rs2,
    output logic [6:0]      iss_rd,
    output logic [IMM-1:0]  iss_imm,
    output logic [CMD-1:0]  iss_cmd,
    input  logic            wb_e_,
    input  logic [4:0]      wb_addr,
    input  logic            flush,
    output logic            exc_e_,
    output logic [ADDR-1:0] exc_pc
);

    localparam logic [2:0] U_NOP = 3'd0;
    localparam logic [2:0] U_ALU = 3'd1;
    localparam logic [2:0] U_DIV = 3'd2;
    localparam logic [2:0] U_MEM = 3'd3;
    localparam logic [2:0] U_CSR = 3'd4;
    localparam logic [1:0] T_GPR = 2'd1;

    logic            entry_v;
    logic [ADDR-1:0] e_pc;
    logic [1:0]      e_rs1_t, e_rs2_t, e_rd_t;
    logic [4:0]      e_rs1_a, e_rs2_a, e_rd_a;
    logic            e_invalid;
    logic [IMM-1:0]  e_imm;
    logic [2:0]      e_unit;
    logic [CMD-1:0]  e_cmd;
    logic [31:0]     busy;

    logic [31:0] wb_mask, busy_eff, set_mask;
    logic        hazard, tgt_ready, fire, issue_go, load;

    always_comb begin
        wb_mask = '0;
        if (!wb_e_)
            wb_mask[wb_addr] = 1'b1;
        // writeback in this cycle already frees its register for the hazard check
        busy_eff = busy & ~wb_mask;
        hazard = (e_rs1_t == T_GPR && busy_eff[e_rs1_a]) ||
                 (e_rs2_t == T_GPR && busy_eff[e_rs2_a]) ||
                 (e_rd_t  == T_GPR && busy_eff[e_rd_a]);
        case (e_unit)
            U_ALU:   tgt_ready = alu_ready;
            U_DIV:   tgt_ready = div_ready;
            U_MEM:   tgt_ready = mem_ready;
            U_CSR:   tgt_ready = csr_ready;
            default: tgt_ready = 1'b1;
        endcase
        if (e_invalid)
            tgt_ready = 1'b1;
    end

    assign fire     = entry_v && !hazard && tgt_ready && !flush;
    assign is_full  = entry_v && !fire;
    assign issue_go = fire && !e_invalid && (e_unit != U_NOP);
    assign load     = !dec_e_ && !is_full && !flush;

    assign alu_issue = issue_go && (e_unit == U_ALU);
    assign div_issue = issue_go && (e_unit == U_DIV);
    assign mem_issue = issue_go && (e_unit == U_MEM);
    assign csr_issue = issue_go && (e_unit == U_CSR);

    assign iss_pc  = issue_go ? e_pc : '0;
    assign iss_rs1 = issue_go ? {e_rs1_t, e_rs1_a} : '0;
    assign iss_rs2 = issue_go ? {e_rs2_t, e_rs2_a} : '0;
    assign iss_rd  = issue_go ? {e_rd_t, e_rd_a} : '0;
    assign iss_imm = issue_go ? e_imm : '0;
    assign iss_cmd = issue_go ? e_cmd : '0;

    assign exc_e_ = !(fire && e_invalid);
    assign exc_pc = (fire && e_invalid) ? e_pc : '0;

    always_comb begin
        set_mask = '0;
        if (issue_go && e_rd_t == T_GPR && e_rd_a != 5'd0)
            set_mask[e_rd_a] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_v <= 1'b0;
            busy    <= '0;
        end else begin
            if (flush)
                entry_v <= 1'b0;
            else if (load)
                entry_v <= 1'b1;
            else if (fire)
                entry_v <= 1'b0;
            // set applied after clear so a same-cycle issue keeps the register busy
            busy <= ((busy & ~wb_mask) | set_mask) & 32'hFFFF_FFFE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_pc      <= '0;
            e_rs1_t   <= '0;
            e_rs2_t   <= '0;
            e_rd_t    <= '0;
            e_rs1_a   <= '0;
            e_rs2_a   <= '0;
            e_rd_a    <= '0;
            e_invalid <= 1'b0;
            e_imm     <= '0;
            e_unit    <= '0;
            e_cmd     <= '0;
        end else if (load) begin
            e_pc      <= dec_pc;
            e_rs1_t   <= dec_rs1_type;
            e_rs2_t   <= dec_rs2_type;
            e_rd_t    <= dec_rd_type;
            e_rs1_a   <= dec_rs1_addr;
            e_rs2_a   <= dec_rs2_addr;
            e_rd_a    <= dec_rd_addr;
            e_invalid <= dec_invalid || (dec_unit > U_CSR);
            e_imm     <= dec_imm;
            e_unit    <= dec_unit;
            e_cmd     <= dec_cmd;
        end
    end

endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 SHALL have parameters: ADDR, default 32, PC width; CMD, default 8, opaque command width; IMM, default 24, packed immediate width.
REQ-002 SHALL have ports, one per line:
  clk  in  1  clock, all state updates on posedge
  reset  in  1  asynchronous, active-high reset
  dec_e_  in  1  decoded-instruction valid, active low
  dec_pc  in  ADDR  instruction PC
  dec_rs1_type, dec_rs2_type, dec_rd_type  in  2 each  0=NONE, 1=GPR, 2=PC, 3=IMM
  dec_rs1_addr, dec_rs2_addr, dec_rd_addr  in  5 each  register indices
  dec_invalid  in  1  illegal-instruction flag
  dec_imm  in  IMM  packed immediate
  dec_unit  in  3  0=NOP, 1=ALU, 2=DIV, 3=MEM, 4=CSR; 5-7 reserved
  dec_cmd  in  CMD  unit command
  is_full  out  1  back-pressure to decoder
  alu_ready, div_ready, mem_ready, csr_ready  in  1 each  unit can accept this cycle
  alu_issue, div_issue, mem_issue, csr_issue  out  1 each  one-cycle issue strobe
  iss_pc, iss_rs1, iss_rs2, iss_rd, iss_imm, iss_cmd  out  per dec_ fields  shared issue bus (type+addr)
  wb_e_  in  1  writeback valid, active low
  wb_addr  in  5  register written back
  flush  in  1  discard held instruction
  exc_e_  out  1  illegal-instruction pulse, active low
  exc_pc  out  ADDR  PC of the illegal instruction

Function
REQ-003 SHALL hold at most one instruction in an issue register (entry_v).
REQ-004 SHALL keep a 32-bit scoreboard busy[31:0]; busy[0] is constant 0.
REQ-005 SHALL define fire = entry_v && !hazard && target ready, where target ready is the ready input of the held unit; NOP units and invalid entries have target ready = 1.
REQ-006 SHALL define hazard as any GPR-typed rs1, rs2 or rd whose busy bit is set after masking the same-cycle writeback (wb bypass).
REQ-007 SHALL drive is_full = entry_v && !fire, combinationally.
REQ-008 SHALL load the entry when dec_e_==0 && !is_full && !flush; on fire without a load, entry_v SHALL clear next cycle.
REQ-009 SHALL, on fire of a valid non-NOP entry, assert exactly one *_issue strobe for that cycle, driving the iss_* bus from the entry.
REQ-010 SHALL, on fire, set busy[rd] when rd is GPR-typed and rd_addr != 0.
REQ-011 SHALL clear busy[wb_addr] when wb_e_==0; if a set and a clear hit the same register in one cycle, the set SHALL win.
REQ-012 SHALL, on fire of an entry with dec_invalid=1, issue nothing, pulse exc_e_=0 for one cycle with exc_pc = entry PC, and leave busy unchanged.
REQ-013 SHALL retire a NOP-unit entry in one cycle with no strobe and no scoreboard change.
REQ-014 SHALL treat reserved unit codes 5-7 as invalid (REQ-012).
REQ-015 SHALL, on flush, clear entry_v next cycle, suppress any fire and decoder load in that cycle, and retain busy bits (in-flight writebacks still return).
REQ-016 SHALL issue with a minimum latency of 1 cycle from decoder accept and sustain 1 issue/cycle when hazard-free and ready.
REQ-017 SHALL keep the iss_* bus at 0 whenever no strobe is asserted.

Reset
REQ-018 SHALL, while reset=1, force entry_v=0, busy=0, all *_issue=0, exc_e_=1, exc_pc=0, iss_*=0 and is_full=0, independently of clk.
REQ-019 SHALL discard any held instruction on reset mid-operation; no strobe SHALL occur in the first cycle after release.

Verification
REQ-020 Back-to-back ALU ops x1=..., x2=... with no dependence and all ready -> alu_issue high on 2 consecutive cycles, is_full stays 0.
REQ-021 DIV writes x5, next ADD reads x5 -> ADD held and is_full=1 until wb_e_=0 with wb_addr=5; ADD issues in that same cycle (bypass), and busy[5] ends 0.
REQ-022 MEM load with mem_ready=0 for 3 cycles -> is_full=1 for 3 cycles, mem_issue once on cycle 4, iss_rd = {GPR, rd}.
REQ-023 Invalid instruction at PC 0x100 -> exc_e_=0 for 1 cycle with exc_pc=0x100, no strobe, busy unchanged.
REQ-024 Issue of rd=x7 coinciding with wb_addr=7 -> busy[7]=1 afterwards; rd=x0 -> busy stays 0.
REQ-025 flush while an entry stalls on a hazard, then reset asserted mid-stall -> entry dropped without issue, all outputs at REQ-018 values.
